vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the raster scan that the game renderer consumes: hCount, vCount and bright for a 640x480 display, plus active-low hSync/vSync for the VGA connector.
- Runs on the 100 MHz board clock and produces a 25 MHz pixel-enable internally.
- Also emits a once-per-frame tick that game logic uses to advance motion and sample the up input.
- Sits between the top level and block_controller; it is the producer of the hCount/vCount/bright interface that block_controller reads.

Parameters:
- CLK_DIV, 4, board clocks per pixel.
- H_TOTAL, 800, pixels per line.
- H_SYNC, 96, hSync low width in pixels, starting at hCount 0.
- H_VIS_START, 144, first visible hCount.
- H_VIS_END, 783, last visible hCount.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width in lines, starting at vCount 0.
- V_VIS_START, 35, first visible vCount.
- V_VIS_END, 514, last visible vCount.

Ports:
- clk  input  1  board clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- pix_en  output  1  one-clk pulse every CLK_DIV clocks; counters advance on it
- hCount  output  10  horizontal position, 0..H_TOTAL-1
- vCount  output  10  vertical position, 0..V_TOTAL-1
- bright  output  1  high inside the visible window
- hSync  output  1  active-low horizontal sync
- vSync  output  1  active-low vertical sync
- frame_tick  output  1  one-clk pulse at end of frame

Behaviour:
- Single clock domain. All state updates on posedge clk. rst is sampled on posedge only.
- Reset, taking effect at the first posedge with rst=1:
  - divider=0, hCount=0, vCount=0, pix_en=0, frame_tick=0.
  - Decoded outputs at reset: hSync=0, vSync=0, bright=0.
- Divider: 2-bit counter, width ceil(log2(CLK_DIV)).
  - Increments every clk and wraps CLK_DIV-1 -> 0.
  - pix_en is registered and high for exactly the clk in which divider==0, excluding the cycle immediately following reset.
  - First pix_en is therefore CLK_DIV clocks after rst deasserts; period is CLK_DIV clocks.
- Horizontal counter, on each clk where pix_en=1:
  - if hCount==H_TOTAL-1, hCount<=0; else hCount<=hCount+1.
  - hCount holds when pix_en=0.
- Vertical counter, on a pix_en clk with hCount==H_TOTAL-1:
  - if vCount==V_TOTAL-1, vCount<=0; else vCount<=vCount+1.
  - Otherwise vCount holds.
- frame_tick: registered.
  - Set to 1 for the single clk following a pix_en clk in which hCount==H_TOTAL-1 and vCount==V_TOTAL-1, i.e. coincident with counters showing (0,0).
  - Otherwise 0.
  - Exactly one pulse per H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clocks.
- Decodes are combinational from the registered counters, so they are valid in the same cycle as the counts they describe:
  - hSync = ~(hCount < H_SYNC)
  - vSync = ~(vCount < V_SYNC)
  - bright = (H_VIS_START <= hCount <= H_VIS_END) && (V_VIS_START <= vCount <= V_VIS_END)
- Visible window is 640x480. Comparisons are unsigned 10-bit. Counters never reach 1023.
- Reset mid-operation:
  - Counters, divider and pulses return to 0 at the next posedge regardless of pix_en.
  - No partial frame_tick is emitted.
  - Scan restarts from (0,0) with the full CLK_DIV startup delay.
- rst held high: all outputs hold their reset values; no pix_en, no frame_tick.
- Simultaneous line wrap and frame wrap are handled in the same pix_en cycle: hCount->0, vCount->0, frame_tick fires next clk.

Test Plan:
- Assert rst for 3 clk, release -> hCount=0, vCount=0, bright=0, hSync=0, vSync=0, frame_tick=0. First pix_en appears exactly 4 clk after release, then every 4 clk.
- Run one line (3200 clk) -> hCount sequence 0..799 then 0. vCount steps 0->1 on the wrap. hSync low exactly for hCount 0..95 (384 clk).
- Check bright boundaries on line vCount=35 -> 0 at hCount 143, 1 at 144 and 783, 0 at 784. Line vCount=34 and vCount=515 -> bright 0 for all hCount. vCount=514 visible.
- Run two full frames -> vSync low only for vCount 0..1. frame_tick high for exactly 1 clk, twice, 1,680,000 clk apart, each coincident with hCount=0, vCount=0.
- Assert rst for 1 clk at hCount=400, vCount=200 -> next clk hCount=0, vCount=0, pix_en=0. Scan resumes with pix_en 4 clk later. No spurious frame_tick.
- Hold rst high for 10,000 clk -> counters stay 0, pix_en and frame_tick never pulse.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster generator: divides the board clock down to a pixel enable,
// scans hCount/vCount, and decodes sync, visible-window and end-of-frame pulses.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 514
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       frame_tick
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             frame_tick_q, frame_tick_d;
  logic             line_end;
  logic             frame_end;

  always_comb begin
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    line_end     = pix_en_q && (h_q == H_LAST);
    frame_end    = line_end && (v_q == V_LAST);
    h_d          = h_q;
    v_d          = v_q;
    if (pix_en_q) begin
      h_d = line_end ? 10'd0 : h_q + 10'd1;
    end
    if (line_end) begin
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
    // pix_en lines up with the divider reaching 0, so the reset value of the
    // divider never produces a pulse.
    pix_en_d     = (div_d == '0);
    frame_tick_d = frame_end;
    if (rst) begin
      div_d        = '0;
      pix_en_d     = 1'b0;
      h_d          = 10'd0;
      v_d          = 10'd0;
      frame_tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    div_q        <= div_d;
    pix_en_q     <= pix_en_d;
    h_q          <= h_d;
    v_q          <= v_d;
    frame_tick_q <= frame_tick_d;
  end

  assign pix_en     = pix_en_q;
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign frame_tick = frame_tick_q;
  assign hSync      = ~(h_q < 10'(H_SYNC));
  assign vSync      = ~(v_q < 10'(V_SYNC));
  assign bright     = (h_q >= 10'(H_VIS_START)) && (h_q <= 10'(H_VIS_END)) &&
                      (v_q >= 10'(V_VIS_START)) && (v_q <= 10'(V_VIS_END));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing is the real 800-pixel line;
// the frame is shortened to 6 lines (sync 0..1, visible 2..4) so two frames fit.
module tb_vga_timing_gen;

  localparam int CLK_DIV = 4;
  localparam int H_TOT   = 800;
  localparam int V_TOT   = 6;
  localparam int H_SYN   = 96;
  localparam int V_SYN   = 2;
  localparam int H_VS    = 144;
  localparam int H_VE    = 783;
  localparam int V_VS    = 2;
  localparam int V_VE    = 4;
  localparam int FRAME_CLK = CLK_DIV * H_TOT * V_TOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       frame_tick;

  int n_checks = 0;
  int n_fails  = 0;
  int cnt      = 0;  // clocks since rst was released

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOT), .H_SYNC(H_SYN),
    .H_VIS_START(H_VS), .H_VIS_END(H_VE),
    .V_TOTAL(V_TOT), .V_SYNC(V_SYN),
    .V_VIS_START(V_VS), .V_VIS_END(V_VE)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hCount(hCount), .vCount(vCount),
    .bright(bright), .hSync(hSync), .vSync(vSync), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference scan model: pixel k is shown in clocks 4k+1..4k+4 after release.
  function automatic int idx_of(int c);
    return (c == 0) ? 0 : ((c - 1) / CLK_DIV) % (H_TOT * V_TOT);
  endfunction
  function automatic logic [9:0] exp_h(int c);
    return 10'(idx_of(c) % H_TOT);
  endfunction
  function automatic logic [9:0] exp_v(int c);
    return 10'(idx_of(c) / H_TOT);
  endfunction
  function automatic logic exp_pix(int c);
    return (c > 0) && (c % CLK_DIV == 0);
  endfunction
  function automatic logic exp_ft(int c);
    return (c > 1) && ((c - 1) % FRAME_CLK == 0);
  endfunction
  function automatic logic exp_bright(int c);
    int h, v;
    h = int'(exp_h(c));
    v = int'(exp_v(c));
    return (h >= H_VS) && (h <= H_VE) && (v >= V_VS) && (v <= V_VE);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({hCount, vCount, bright, hSync, vSync, frame_tick, pix_en} !== 25'd0) begin
        n_fails++;
        $display("FAIL reset_state: h=%0d v=%0d br=%b hs=%b vs=%b ft=%b pe=%b, required all 0",
                 hCount, vCount, bright, hSync, vSync, frame_tick, pix_en);
      end
    end
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (pix_en !== exp_pix(cnt)) begin
        n_fails++;
        $display("FAIL startup_pix_en: clk %0d after release pix_en=%b, required %b",
                 cnt, pix_en, exp_pix(cnt));
      end
    end
  endtask

  task automatic test_line();
    int hs_low;
    do_reset(2);
    hs_low = 0;
    while (cnt < H_TOT * CLK_DIV + 4) begin
      tick();
      if (cnt <= H_TOT * CLK_DIV && hSync === 1'b0) hs_low++;
      n_checks++;
      if (hCount !== exp_h(cnt) || vCount !== exp_v(cnt)) begin
        n_fails++;
        $display("FAIL line_counts: clk %0d h=%0d v=%0d, required h=%0d v=%0d",
                 cnt, hCount, vCount, exp_h(cnt), exp_v(cnt));
      end
      n_checks++;
      if (hSync !== (exp_h(cnt) >= 10'(H_SYN))) begin
        n_fails++;
        $display("FAIL line_hsync: clk %0d h=%0d hSync=%b", cnt, hCount, hSync);
      end
    end
    n_checks++;
    if (hs_low !== 384) begin
      n_fails++;
      $display("FAIL hsync_width: low for %0d clk, required 384", hs_low);
    end
    n_checks++;
    if (hCount !== 10'd0 || vCount !== 10'd1) begin
      n_fails++;
      $display("FAIL line_wrap: h=%0d v=%0d, required h=0 v=1", hCount, vCount);
    end
  endtask

  // Continues the scan from test_line; hand-picked points around the window edges.
  task automatic test_bright();
    int pts_v[10] = '{1, 1, 2, 2, 2, 2, 4, 4, 5, 5};
    int pts_h[10] = '{144, 500, 143, 144, 783, 784, 144, 783, 144, 500};
    logic pts_b[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int p = 0; p < 10; p++) begin
      while (cnt < CLK_DIV * (pts_v[p] * H_TOT + pts_h[p]) + 1) tick();
      n_checks++;
      if (hCount !== 10'(pts_h[p]) || vCount !== 10'(pts_v[p]) || bright !== pts_b[p]) begin
        n_fails++;
        $display("FAIL bright_edge: h=%0d v=%0d bright=%b, required h=%0d v=%0d bright=%b",
                 hCount, vCount, bright, pts_h[p], pts_v[p], pts_b[p]);
      end
    end
  endtask

  // Continues the same scan through the end of the second frame.
  task automatic test_frames();
    int n_ft, last_ft;
    n_ft = 0;
    last_ft = 0;
    while (cnt < 2 * FRAME_CLK + 8) begin
      tick();
      if (frame_tick === 1'b1) begin
        n_ft++;
        n_checks++;
        if (n_ft == 2 && cnt - last_ft != FRAME_CLK) begin
          n_fails++;
          $display("FAIL frame_period: %0d clk between ticks, required %0d",
                   cnt - last_ft, FRAME_CLK);
        end
        last_ft = cnt;
      end
      n_checks++;
      if (hCount !== exp_h(cnt) || vCount !== exp_v(cnt) || pix_en !== exp_pix(cnt)) begin
        n_fails++;
        $display("FAIL frame_counts: clk %0d h=%0d v=%0d pe=%b, required h=%0d v=%0d pe=%b",
                 cnt, hCount, vCount, pix_en, exp_h(cnt), exp_v(cnt), exp_pix(cnt));
      end
      n_checks++;
      if (frame_tick !== exp_ft(cnt)) begin
        n_fails++;
        $display("FAIL frame_tick: clk %0d h=%0d v=%0d frame_tick=%b, required %b",
                 cnt, hCount, vCount, frame_tick, exp_ft(cnt));
      end
      n_checks++;
      if (vSync !== (exp_v(cnt) >= 10'(V_SYN)) || bright !== exp_bright(cnt)) begin
        n_fails++;
        $display("FAIL frame_decode: clk %0d h=%0d v=%0d vSync=%b bright=%b, required %b %b",
                 cnt, hCount, vCount, vSync, bright, exp_v(cnt) >= 10'(V_SYN), exp_bright(cnt));
      end
    end
    n_checks++;
    if (n_ft !== 2) begin
      n_fails++;
      $display("FAIL frame_tick_count: %0d pulses, required 2", n_ft);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    while (cnt < CLK_DIV * (1 * H_TOT + 400) + 1) tick();
    n_checks++;
    if (hCount !== 10'd400 || vCount !== 10'd1) begin
      n_fails++;
      $display("FAIL mid_reset_pos: h=%0d v=%0d, required h=400 v=1", hCount, vCount);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (hCount !== 10'd0 || vCount !== 10'd0 || pix_en !== 1'b0 || frame_tick !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_reset_clear: h=%0d v=%0d pe=%b ft=%b, required all 0",
               hCount, vCount, pix_en, frame_tick);
    end
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (pix_en !== exp_pix(cnt) || hCount !== exp_h(cnt) || frame_tick !== 1'b0) begin
        n_fails++;
        $display("FAIL mid_reset_resume: clk %0d pe=%b h=%0d ft=%b, required pe=%b h=%0d ft=0",
                 cnt, pix_en, hCount, frame_tick, exp_pix(cnt), exp_h(cnt));
      end
    end
  endtask

  task automatic test_hold_reset();
    int bad;
    bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tick();
      n_checks++;
      if ({hCount, vCount, pix_en, frame_tick, hSync, vSync, bright} !== 25'd0) begin
        n_fails++;
        if (bad < 5)
          $display("FAIL hold_reset: clk %0d h=%0d v=%0d pe=%b ft=%b, required all 0",
                   i, hCount, vCount, pix_en, frame_tick);
        bad++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line();
    test_bright();
    test_frames();
    test_mid_reset();
    test_hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
